thrive_pe_rst_seq: RTL
======================

// Module: thrive_pe_rst_seq
// PURPOSE
//  Per-PE reset release sequencer and completion monitor for N processing elements.
//  Sits between the top-level sys_rstn and each <pe>_sys_rstn input of thrive_top_wrapper.
//  Releases the enabled PEs one at a time, staggered, then collects per-PE done flags.
//  Reports all-done, timeout and elapsed cycles to the finish logic.
// PARAMETERS
//  NUM_PE       4   number of PE channels (1..32)
//  STAGGER_CYC  8   cycles between consecutive PE reset releases (>=1)
//  SYNC_STAGES  2   flop stages on each pe_done input (>=1)
//  TIMEOUT_W    32  width of timeout limit and cycle counter
// PORTS
//  sys_clk      in   1          single clock for all logic
//  sys_rstn     in   1          async active-low reset
//  start        in   1          1-cycle pulse: begin sequence (accepted in IDLE only)
//  clr          in   1          1-cycle pulse: reassert all PE resets, return to IDLE
//  pe_en        in   NUM_PE     PE enable mask, sampled when start is accepted
//  timeout_lmt  in   TIMEOUT_W  RUN-phase cycle limit; 0 disables timeout
//  pe_done      in   NUM_PE     level done flags from PEs
//  pe_rstn      out  NUM_PE     per-PE active-low reset
//  done_vec     out  NUM_PE     sticky per-PE done (enabled PEs only)
//  busy         out  1          high in RELEASE or RUN
//  all_done     out  1          high in DONE
//  timeout      out  1          high in TIMEOUT
//  cyc_cnt      out  TIMEOUT_W  cycles spent in RUN; saturates at all-ones
// BEHAVIOUR
//  Reset (sys_rstn=0, async): state IDLE. pe_rstn, done_vec, busy, all_done, timeout and
//   cyc_cnt all 0. Sync flops and all counters cleared.
//  FSM states: IDLE, RELEASE, RUN, DONE, TIMEOUT.
//  IDLE, start=1:
//   - Latch pe_en into en_q.
//   - en_q==0: go to DONE next cycle.
//   - Otherwise go to RELEASE.
//  RELEASE:
//   - The lowest-index enabled PE has its pe_rstn set to 1 on the first RELEASE cycle.
//     This is 1 cycle after start.
//   - Each next enabled PE, in ascending index order, is released exactly STAGGER_CYC
//     cycles after the previous one.
//   - Disabled PEs take no slot and their pe_rstn stays 0.
//   - After the last enabled PE is released, go to RUN next cycle.
//  RUN:
//   - cyc_cnt increments every cycle.
//   - Go to TIMEOUT when timeout_lmt!=0 and cyc_cnt==timeout_lmt-1.
//   - Go to DONE when (done_vec & en_q)==en_q.
//   - If both conditions hold in the same cycle, DONE wins.
//  Done capture:
//   - pe_done[i] passes through SYNC_STAGES flops.
//   - The synced value sets done_vec[i] only if en_q[i]=1 and pe_rstn[i]=1.
//   - done_vec is sticky until clr or reset. Capture is active in RELEASE and RUN.
//   - Latency: pe_done rise to done_vec = SYNC_STAGES+1 cycles.
//  DONE / TIMEOUT:
//   - Terminal until clr. pe_rstn stays released so PE state can be inspected.
//   - done_vec and cyc_cnt are frozen. start is ignored.
//  clr (any state):
//   - Next cycle: IDLE, pe_rstn=0, done_vec=0, cyc_cnt=0.
//   - clr has priority over start in the same cycle.
//  start outside IDLE is ignored. pe_en changes after start have no effect.
//  sys_rstn asserted mid-sequence: all PEs return to reset immediately (async).
// TESTING
//  T1 NUM_PE=4, pe_en=4'b1111, start@c0 -> pe_rstn bits rise at c1,c9,c17,c25;
//     RUN from c26.
//  T2 pe_en=4'b1010 -> pe_rstn[1] rises c1, pe_rstn[3] rises c9; bits 0 and 2 stay 0;
//     done on pe_done[0] is ignored.
//  T3 All enabled PEs raise pe_done in RUN -> all_done=1 SYNC_STAGES+2 cycles after the
//     last pe_done; done_vec==en_q.
//  T4 timeout_lmt=100 with no pe_done -> timeout=1 after 100 RUN cycles; cyc_cnt==100.
//     Same cycle as final done -> all_done wins.
//  T5 pe_en=0, start -> all_done=1 after 1 cycle; pe_rstn stays 0.
//  T6 clr in RELEASE and start+clr together -> IDLE, all outputs 0 next cycle.
//     sys_rstn low mid-RUN -> pe_rstn=0 async.

Source files
------------

// File: rtl/thrive_pe_rst_seq.sv
// Per-PE reset release sequencer and completion monitor.
// Staggers PE reset release, collects done flags, reports done/timeout.
module thrive_pe_rst_seq #(
    parameter int NUM_PE      = 4,
    parameter int STAGGER_CYC = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 start,
    input  logic                 clr,
    input  logic [NUM_PE-1:0]    pe_en,
    input  logic [TIMEOUT_W-1:0] timeout_lmt,
    input  logic [NUM_PE-1:0]    pe_done,
    output logic [NUM_PE-1:0]    pe_rstn,
    output logic [NUM_PE-1:0]    done_vec,
    output logic                 busy,
    output logic                 all_done,
    output logic                 timeout,
    output logic [TIMEOUT_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REL,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    localparam int CW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYC - 1);

    state_t                state_q;
    state_t                state_d;
    logic [NUM_PE-1:0]     en_q;
    logic [NUM_PE-1:0]     rel_q;
    logic [NUM_PE-1:0]     rem_q;
    logic [CW-1:0]         stg_q;
    logic [NUM_PE-1:0]     dvec_q;
    logic [TIMEOUT_W-1:0]  cyc_q;
    logic [NUM_PE-1:0]     sync_q [SYNC_STAGES];

    logic [NUM_PE-1:0]     en_low;
    logic [NUM_PE-1:0]     rem_low;
    logic                  all_hit;
    logic                  tmo_hit;

    // Lowest set bit picks the next PE to release, in ascending order.
    assign en_low  = pe_en & (~pe_en + NUM_PE'(1));
    assign rem_low = rem_q & (~rem_q + NUM_PE'(1));
    assign all_hit = ((dvec_q & en_q) == en_q);
    assign tmo_hit = (timeout_lmt != '0) &&
                     (cyc_q == timeout_lmt - TIMEOUT_W'(1));

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; clr overrides everything, DONE beats TIMEOUT.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) state_d = (pe_en == '0) ? S_DONE : S_REL;
                S_REL:  if (rem_q == '0) state_d = S_RUN;
                S_RUN: begin
                    if (all_hit)      state_d = S_DONE;
                    else if (tmo_hit) state_d = S_TMO;
                end
                S_DONE: state_d = S_DONE;
                S_TMO:  state_d = S_TMO;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy     = (state_q == S_REL) || (state_q == S_RUN);
        all_done = (state_q == S_DONE);
        timeout  = (state_q == S_TMO);
    end

    // Synchronizer chain on the asynchronous PE done flags.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pe_done;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Release schedule, sticky done capture and RUN cycle counter.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            en_q   <= '0;
            rel_q  <= '0;
            rem_q  <= '0;
            stg_q  <= '0;
            dvec_q <= '0;
            cyc_q  <= '0;
        end else if (clr) begin
            en_q   <= '0;
            rel_q  <= '0;
            rem_q  <= '0;
            stg_q  <= '0;
            dvec_q <= '0;
            cyc_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        en_q  <= pe_en;
                        rel_q <= en_low;
                        rem_q <= pe_en & ~en_low;
                        stg_q <= '0;
                    end
                end
                S_REL: begin
                    if (rem_q != '0) begin
                        if (stg_q == STG_LAST) begin
                            rel_q <= rel_q | rem_low;
                            rem_q <= rem_q & ~rem_low;
                            stg_q <= '0;
                        end else begin
                            stg_q <= stg_q + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cyc_q != '1) cyc_q <= cyc_q + TIMEOUT_W'(1);
                end
                default: ;
            endcase
            if (state_q == S_REL || state_q == S_RUN)
                dvec_q <= dvec_q | (sync_q[SYNC_STAGES-1] & en_q & rel_q);
        end
    end

    assign pe_rstn  = rel_q;
    assign done_vec = dvec_q;
    assign cyc_cnt  = cyc_q;

endmodule
